trigger_trace_buffer: RTL and testbench
=======================================

// Module: trigger_trace_buffer
// PURPOSE
//  Next-generation circular trace buffer for the debug datapath: stores N-lane vectors plus a compression flag per entry.
//  Adds trigger/post-trigger freeze, one-shot vs circular capture, occupancy/wrap tracking and an oldest-first drain port.
//  The drain port uses a valid/ready handshake. Sits at the tail of the vector pipeline; the drain feeds the host readout path.
// PARAMETERS
//  N           8   vector lanes per entry
//  DATA_WIDTH  32  bits per lane
//  TB_SIZE     64  entries, power of two >= 2; AW = $clog2(TB_SIZE), CW = $clog2(TB_SIZE+1)
// PORTS
//  clk                   in   1           single clock; all logic on posedge
//  rst_n                 in   1           asynchronous active-low reset
//  tracing               in   1           capture enable; low = no write, no ptr move, triggers ignored
//  valid_in              in   1           sample valid; writes slot wr_ptr while capturing
//  inc_tb_ptr            in   1           with valid_in: commit sample, advance wr_ptr
//  compression_flag_in   in   1           flag stored alongside vector
//  vector_in             in   N x DW      sample lanes
//  mode_oneshot          in   1           1 = stop when full; 0 = circular overwrite
//  trigger_in            in   1           trigger event (sampled in ARMED only)
//  post_trig_len         in   CW          committed samples after trigger before freeze (latched at trigger)
//  rearm                 in   1           FROZEN -> ARMED, discards contents
//  dump_req              in   1           FROZEN -> DRAIN
//  dump_ready            in   1           consumer ready
//  dump_valid            out  1           drain beat valid
//  dump_last             out  1           final beat of drain
//  vector_out            out  N x DW      drain data
//  compression_flag_out  out  1           drain flag
//  occupancy             out  CW          committed entries, saturates at TB_SIZE
//  wrapped               out  1           circular capture has overwritten entry 0
//  trig_addr             out  AW          slot of trigger-cycle sample
//  state_o               out  2           0 ARMED, 1 POST, 2 FROZEN, 3 DRAIN
// BEHAVIOUR
//  - Reset (async on rst_n low): state ARMED, wr_ptr 0, occupancy 0, wrapped 0, trig_addr 0.
//    Reset also forces dump_valid/dump_last 0, vector_out 0, flag 0. Memory contents are not cleared.
//  - Capturing = tracing & state in {ARMED, POST}.
//  - Write when capturing & valid_in. The sample is committed only if inc_tb_ptr is also high.
//    valid without inc rewrites the same slot.
//  - Commit: wr_ptr wraps TB_SIZE-1 -> 0. Occupancy increments up to TB_SIZE.
//    wrapped sets on the first commit made while occupancy == TB_SIZE (circular mode).
//  - One-shot: when occupancy == TB_SIZE, next cycle -> FROZEN from ARMED or POST. Further samples are dropped.
//  - ARMED & tracing & trigger_in:
//    trig_addr <= wr_ptr, postcnt <= post_trig_len, state -> POST.
//    The trigger-cycle sample, if committed, is not counted in postcnt.
//    If post_trig_len == 0, go straight to FROZEN (trigger-cycle sample kept).
//  - POST: each commit decrements postcnt; the commit that makes it 0 is stored, then state -> FROZEN.
//    trigger_in is ignored in POST.
//  - FROZEN: no writes. rearm -> ARMED and clears wr_ptr, occupancy and wrapped.
//    Otherwise dump_req -> DRAIN. If both are high, rearm wins.
//    dump_req/rearm are ignored in ARMED/POST; rearm is ignored in DRAIN.
//  - DRAIN reads oldest first:
//    start = wrapped ? wr_ptr : 0; beats = occupancy; address increments mod TB_SIZE.
//  - Read path latency: RAM read 1 cycle plus registered output, with a 2-entry skid.
//    First dump_valid appears 2 cycles after the DRAIN entry edge.
//    With dump_ready held high, sustain 1 beat/cycle.
//  - Handshake: a beat transfers on dump_valid & dump_ready.
//    While dump_valid & !dump_ready, data/flag/last are held stable. No loss or duplication.
//  - dump_last is high only with the final beat. After it transfers -> ARMED with pointers, occupancy and wrapped cleared.
//  - DRAIN with occupancy 0: no beats; -> ARMED next cycle.
//  - Capture logic is inactive in DRAIN. Memory port A writes only while capturing; port B reads only in DRAIN.
// TESTING  (TB_SIZE=8, N=2, DW=8)
//  1. Circular: commit values 1..11, trigger on 11 with post_trig_len 0
//     -> FROZEN, occupancy 8, wrapped 1; dump yields 4..11, last on 11.
//  2. One-shot: commit 1..10, no trigger -> FROZEN after 8th, 9 and 10 dropped; dump yields 1..8, wrapped 0.
//  3. Trigger on sample 3, post_trig_len 2, commit 1..7
//     -> FROZEN after 5, trig_addr 2, occupancy 5; dump 1..5.
//  4. Drain 8 entries with dump_ready toggling pseudo-randomly
//     -> exactly 8 transfers in order, outputs stable while stalled, one dump_last.
//  5. rst_n low after 3 transferred beats -> dump_valid 0 immediately, state ARMED, occupancy 0; new capture works.
//  6. valid_in without inc_tb_ptr (A, then B), then valid+inc C, trigger post 0
//     -> occupancy 1, dump yields C; tracing low blocks writes and triggers.

Source files
------------

// File: rtl/trigger_trace_buffer.sv
// Circular trace buffer for the debug datapath.
// Captures N-lane vectors plus a compression flag per entry, freezes a programmable number of
// committed samples after a trigger (or when full in one-shot mode), and drains oldest-first
// through a valid/ready port.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   tracing_i              capture enable
//   valid_i, inc_tb_ptr_i  sample write / commit
//   compression_flag_i     flag stored with each vector
//   vector_i               sample lanes
//   mode_oneshot_i         1 = stop when full, 0 = circular overwrite
//   trigger_i              trigger event (ARMED only)
//   post_trig_len_i        committed samples after trigger before freeze
//   rearm_i, dump_req_i    FROZEN -> ARMED / FROZEN -> DRAIN
//   dump_ready_i           consumer ready
//   dump_valid_o, dump_last_o, vector_o, compression_flag_o   drain beat
//   occupancy_o, wrapped_o, trig_addr_o, state_o              status
module trigger_trace_buffer #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TB_SIZE    = 64,
  localparam int unsigned AW        = $clog2(TB_SIZE),
  localparam int unsigned CW        = $clog2(TB_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             tracing_i,
  input  logic                             valid_i,
  input  logic                             inc_tb_ptr_i,
  input  logic                             compression_flag_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_i,
  input  logic                             mode_oneshot_i,
  input  logic                             trigger_i,
  input  logic [CW-1:0]                    post_trig_len_i,
  input  logic                             rearm_i,
  input  logic                             dump_req_i,
  input  logic                             dump_ready_i,
  output logic                             dump_valid_o,
  output logic                             dump_last_o,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_o,
  output logic                             compression_flag_o,
  output logic [CW-1:0]                    occupancy_o,
  output logic                             wrapped_o,
  output logic [AW-1:0]                    trig_addr_o,
  output logic [1:0]                       state_o
);

  localparam int unsigned DW = N * DATA_WIDTH;
  localparam int unsigned EW = DW + 1;
  localparam logic [CW-1:0] Full = CW'(TB_SIZE);

  localparam logic [1:0] StArmed  = 2'd0;
  localparam logic [1:0] StPost   = 2'd1;
  localparam logic [1:0] StFrozen = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          wrapped_q, wrapped_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [CW-1:0] postcnt_q, postcnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] rd_left_q, rd_left_d;
  logic          inflight_q, inflight_last_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [EW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_last_q, out_last_d, skid_last_q, skid_last_d;

  logic [EW-1:0] mem_q [TB_SIZE];
  logic [EW-1:0] rd_data_q;

  logic       capturing, full, oneshot_full, wr_en, commit;
  logic       in_drain, pop, push, rd_issue, drain_done, drain_empty;
  logic [1:0] cnt_after_pop;
  logic [2:0] pipe_fill, pipe_cap;

  assign capturing    = tracing_i && (state_q == StArmed || state_q == StPost);
  assign full         = (occ_q == Full);
  assign oneshot_full = mode_oneshot_i && full;
  assign wr_en        = capturing && valid_i && !oneshot_full;
  assign commit       = wr_en && inc_tb_ptr_i;

  assign in_drain      = (state_q == StDrain);
  assign pop           = (cnt_q != 2'd0) && dump_ready_i;
  assign push          = inflight_q;
  assign cnt_after_pop = cnt_q - {1'b0, pop};
  // Only issue a read if its data is guaranteed a slot in the 2-entry output queue.
  assign pipe_fill     = {1'b0, cnt_q} + {2'b0, inflight_q};
  assign pipe_cap      = 3'd2 + {2'b0, pop};
  assign rd_issue      = in_drain && (rd_left_q != '0) && (pipe_fill < pipe_cap);
  assign drain_done    = pop && out_last_q;
  assign drain_empty   = in_drain && (rd_left_q == '0) && !inflight_q && (cnt_q == 2'd0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    postcnt_d   = postcnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_left_d   = rd_left_q;

    if (commit) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      // A commit while full can only happen in circular mode.
      if (full) wrapped_d = 1'b1;
      else      occ_d     = occ_q + 1'b1;
    end

    case (state_q)
      StArmed: begin
        if (oneshot_full) begin
          state_d = StFrozen;
        end else if (tracing_i && trigger_i) begin
          trig_addr_d = wr_ptr_q;
          postcnt_d   = post_trig_len_i;
          state_d     = (post_trig_len_i == '0) ? StFrozen : StPost;
        end
      end
      StPost: begin
        if (oneshot_full) begin
          state_d = StFrozen;
        end else if (commit) begin
          postcnt_d = postcnt_q - 1'b1;
          if (postcnt_q == CW'(1)) state_d = StFrozen;
        end
      end
      StFrozen: begin
        if (rearm_i) begin
          state_d   = StArmed;
          wr_ptr_d  = '0;
          occ_d     = '0;
          wrapped_d = 1'b0;
        end else if (dump_req_i) begin
          state_d   = StDrain;
          rd_ptr_d  = wrapped_q ? wr_ptr_q : '0;
          rd_left_d = occ_q;
        end
      end
      default: begin
        if (rd_issue) begin
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_left_d = rd_left_q - 1'b1;
        end
        if (drain_done || drain_empty) begin
          state_d   = StArmed;
          wr_ptr_d  = '0;
          occ_d     = '0;
          wrapped_d = 1'b0;
          rd_ptr_d  = '0;
        end
      end
    endcase
  end

  // Output queue: out_q is the head presented on the port, skid_q the second entry.
  always_comb begin
    out_d       = out_q;
    out_last_d  = out_last_q;
    skid_d      = skid_q;
    skid_last_d = skid_last_q;
    if (pop) begin
      out_d      = skid_q;
      out_last_d = skid_last_q;
    end
    if (push) begin
      if (cnt_after_pop == 2'd0) begin
        out_d      = rd_data_q;
        out_last_d = inflight_last_q;
      end else begin
        skid_d      = rd_data_q;
        skid_last_d = inflight_last_q;
      end
    end
    cnt_d = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StArmed;
      wr_ptr_q        <= '0;
      occ_q           <= '0;
      wrapped_q       <= 1'b0;
      trig_addr_q     <= '0;
      postcnt_q       <= '0;
      rd_ptr_q        <= '0;
      rd_left_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      cnt_q           <= 2'd0;
      out_q           <= '0;
      out_last_q      <= 1'b0;
      skid_q          <= '0;
      skid_last_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      occ_q           <= occ_d;
      wrapped_q       <= wrapped_d;
      trig_addr_q     <= trig_addr_d;
      postcnt_q       <= postcnt_d;
      rd_ptr_q        <= rd_ptr_d;
      rd_left_q       <= rd_left_d;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (rd_left_q == CW'(1));
      cnt_q           <= cnt_d;
      out_q           <= out_d;
      out_last_q      <= out_last_d;
      skid_q          <= skid_d;
      skid_last_q     <= skid_last_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en)    mem_q[wr_ptr_q] <= {compression_flag_i, vector_i};
    if (rd_issue) rd_data_q       <= mem_q[rd_ptr_q];
  end

  assign dump_valid_o       = (cnt_q != 2'd0);
  assign dump_last_o        = dump_valid_o && out_last_q;
  assign vector_o           = out_q[DW-1:0];
  assign compression_flag_o = out_q[DW];
  assign occupancy_o        = occ_q;
  assign wrapped_o          = wrapped_q;
  assign trig_addr_o        = trig_addr_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_trigger_trace_buffer.sv
// Directed bench for trigger_trace_buffer (TB_SIZE=8, N=2, DATA_WIDTH=8).
module tb_trigger_trace_buffer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tracing, valid, inc, flag_in, oneshot, trigger, rearm, dump_req, dump_ready;
  logic [1:0][7:0] vector_in, vector_out;
  logic [3:0]      post_len, occupancy;
  logic            dump_valid, dump_last, flag_out, wrapped;
  logic [2:0]      trig_addr;
  logic [1:0]      state;

  int checks = 0;
  int errors = 0;

  trigger_trace_buffer #(.N(2), .DATA_WIDTH(8), .TB_SIZE(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .tracing_i          (tracing),
    .valid_i            (valid),
    .inc_tb_ptr_i       (inc),
    .compression_flag_i (flag_in),
    .vector_i           (vector_in),
    .mode_oneshot_i     (oneshot),
    .trigger_i          (trigger),
    .post_trig_len_i    (post_len),
    .rearm_i            (rearm),
    .dump_req_i         (dump_req),
    .dump_ready_i       (dump_ready),
    .dump_valid_o       (dump_valid),
    .dump_last_o        (dump_last),
    .vector_o           (vector_out),
    .compression_flag_o (flag_out),
    .occupancy_o        (occupancy),
    .wrapped_o          (wrapped),
    .trig_addr_o        (trig_addr),
    .state_o            (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] exp_beat(input logic [7:0] v);
    logic [7:0] hi;
    hi = v + 8'h80;
    return {v[0], hi, v};
  endfunction

  // One sample cycle; inputs set just after an edge, taken on the next edge.
  task automatic smp(input logic [7:0] v, input bit trc, input bit commit_it, input bit trg,
                     input logic [3:0] plen);
    logic [7:0] hi;
    hi        = v + 8'h80;
    tracing   = trc;
    valid     = 1'b1;
    inc       = commit_it;
    trigger   = trg;
    post_len  = plen;
    vector_in = {hi, v};
    flag_in   = v[0];
    @(posedge clk); #1;
    valid   = 1'b0;
    inc     = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic drain(input logic [7:0] start, input int n, input bit rnd, output int first_cyc);
    int k, cyc, lasts;
    bit stalled;
    logic [17:0] held, beat;
    k = 0; cyc = 0; lasts = 0; stalled = 0; first_cyc = -1; held = '0;
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    while (k < n && cyc < 200) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      beat = {dump_last, flag_out, vector_out};
      if (stalled) chk("stall_hold", {13'd0, dump_valid, beat}, {13'd0, 1'b1, held});
      if (dump_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (dump_ready) begin
          chk("beat_data", {15'd0, beat[16:0]}, {15'd0, exp_beat(start + 8'(k))});
          chk("beat_last", {31'd0, dump_last}, {31'd0, k == n - 1});
          if (dump_last) lasts++;
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held    = beat;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    dump_ready = 1'b0;
    chk("drain_beats", k, n);
    chk("drain_lasts", lasts, 1);
    chk("drain_state", {30'd0, state}, 32'd0);
    chk("drain_occ", {28'd0, occupancy}, 32'd0);
    chk("drain_wrapped", {31'd0, wrapped}, 32'd0);
  endtask

  initial begin
    int fc, k, cyc;
    rst_n = 1'b0; tracing = 1'b0; valid = 1'b0; inc = 1'b0; flag_in = 1'b0;
    oneshot = 1'b0; trigger = 1'b0; rearm = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    post_len = 4'd0; vector_in = '0;
    #12;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_occ", {28'd0, occupancy}, 32'd0);
    chk("rst_wrapped", {31'd0, wrapped}, 32'd0);
    chk("rst_trig", {29'd0, trig_addr}, 32'd0);
    chk("rst_out", {14'd0, dump_valid, dump_last, flag_out, vector_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // 1. Circular wrap, trigger on 11 with no post-trigger window.
    for (int v = 1; v <= 10; v++) smp(8'(v), 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd11, 1'b1, 1'b1, 1'b1, 4'd0);
    chk("t1_state", {30'd0, state}, 32'd2);
    chk("t1_occ", {28'd0, occupancy}, 32'd8);
    chk("t1_wrapped", {31'd0, wrapped}, 32'd1);
    chk("t1_trig", {29'd0, trig_addr}, 32'd2);
    drain(8'd4, 8, 1'b0, fc);
    chk("t1_latency", fc, 2);

    // 2. One-shot: stops after 8, 9 and 10 dropped.
    oneshot = 1'b1;
    for (int v = 1; v <= 10; v++) smp(8'(v), 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t2_state", {30'd0, state}, 32'd2);
    chk("t2_occ", {28'd0, occupancy}, 32'd8);
    chk("t2_wrapped", {31'd0, wrapped}, 32'd0);
    drain(8'd1, 8, 1'b0, fc);
    oneshot = 1'b0;

    // 3. Trigger on sample 3 with two post-trigger commits.
    smp(8'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd3, 1'b1, 1'b1, 1'b1, 4'd2);
    chk("t3_post", {30'd0, state}, 32'd1);
    smp(8'd4, 1'b1, 1'b1, 1'b1, 4'd0);
    smp(8'd5, 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd6, 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd7, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("t3_state", {30'd0, state}, 32'd2);
    chk("t3_trig", {29'd0, trig_addr}, 32'd2);
    chk("t3_occ", {28'd0, occupancy}, 32'd5);
    drain(8'd1, 5, 1'b0, fc);

    // 4. Full drain with a toggling consumer.
    oneshot = 1'b1;
    for (int v = 21; v <= 28; v++) smp(8'(v), 1'b1, 1'b1, 1'b0, 4'd0);
    idle();
    chk("t4_state", {30'd0, state}, 32'd2);
    drain(8'd21, 8, 1'b1, fc);
    oneshot = 1'b0;

    // 5. Reset in the middle of a drain.
    for (int v = 31; v <= 36; v++) smp(8'(v), 1'b1, 1'b1, 1'b0, 4'd0);
    smp(8'd37, 1'b1, 1'b1, 1'b1, 4'd0);
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    idle();
    dump_req = 1'b0;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 20) begin
      if (dump_valid && dump_ready) k++;
      idle();
      cyc++;
    end
    chk("t5_beats", k, 3);
    chk("t5_before", {31'd0, dump_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, dump_valid}, 32'd0);
    chk("t5_state", {30'd0, state}, 32'd0);
    chk("t5_occ", {28'd0, occupancy}, 32'd0);
    dump_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    smp(8'd50, 1'b1, 1'b1, 1'b1, 4'd0);
    chk("t5_recap", {30'd0, state}, 32'd2);
    drain(8'd50, 1, 1'b0, fc);

    // 6. Overwrites without commit, and tracing low blocking everything.
    smp(8'd60, 1'b0, 1'b1, 1'b1, 4'd0);
    chk("t6_notrace_state", {30'd0, state}, 32'd0);
    chk("t6_notrace_occ", {28'd0, occupancy}, 32'd0);
    smp(8'h0A, 1'b1, 1'b0, 1'b0, 4'd0);
    smp(8'h0B, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("t6_nocommit_occ", {28'd0, occupancy}, 32'd0);
    smp(8'h0C, 1'b1, 1'b1, 1'b1, 4'd0);
    chk("t6_state", {30'd0, state}, 32'd2);
    chk("t6_occ", {28'd0, occupancy}, 32'd1);
    chk("t6_trig", {29'd0, trig_addr}, 32'd0);
    drain(8'h0C, 1, 1'b0, fc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
